// File: rtl/register_dump_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | register_dump_sequencer: streams a header byte then every register          |
// | (MSB byte first) to a byte-wide UART TX over a start/busy handshake.        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module register_dump_sequencer #(
  parameter int         NUM_REGS    = 32,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dump_start,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_index,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        dump_busy,
  output logic        dump_done
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_HEADER = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_LOAD   = 3'd3;
  localparam logic [2:0] c_SEND   = 3'd4;
  localparam logic [2:0] c_ACK    = 3'd5;
  localparam logic [2:0] c_WAIT   = 3'd6;
  localparam logic [2:0] c_DONE   = 3'd7;

  localparam logic [4:0] c_LAST_IDX = 5'(NUM_REGS - 1);

  logic [2:0]  r_state;
  logic [4:0]  r_reg_index;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_dump_busy;
  logic        r_dump_done;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_capture;
  logic        r_hdr_flag;
  logic [7:0]  w_send_byte;

  // Byte n of the word sits at bit 31-8n, i.e. {~n, 3'b111} for a 2-bit n.
  assign w_send_byte = r_capture[{~r_byte_cnt, 3'b111} -: 8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_reg_index <= 5'd0;
      r_tx_data   <= 8'd0;
      r_tx_start  <= 1'b0;
      r_dump_busy <= 1'b0;
      r_dump_done <= 1'b0;
      r_byte_cnt  <= 2'd0;
      r_capture   <= 32'd0;
      r_hdr_flag  <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_dump_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (dump_start) begin
            r_state     <= c_HEADER;
            r_reg_index <= 5'd0;
            r_byte_cnt  <= 2'd0;
            r_dump_busy <= 1'b1;
          end
        end
        c_HEADER: begin
          if (!tx_busy) begin
            r_tx_data  <= HEADER_BYTE;
            r_tx_start <= 1'b1;
            r_hdr_flag <= 1'b1;
            r_state    <= c_ACK;
          end
        end
        // tx_busy rises one cycle after tx_start; ACK hides that gap from WAIT.
        c_ACK: begin
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (!tx_busy) begin
            if (r_hdr_flag) begin
              r_hdr_flag <= 1'b0;
              r_state    <= c_SETTLE;
            end else if (r_byte_cnt != 2'd3) begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_state    <= c_SEND;
            end else if (r_reg_index == c_LAST_IDX) begin
              r_state <= c_DONE;
            end else begin
              r_reg_index <= r_reg_index + 5'd1;
              r_byte_cnt  <= 2'd0;
              r_state     <= c_SETTLE;
            end
          end
        end
        c_SETTLE: begin
          r_state <= c_LOAD;
        end
        c_LOAD: begin
          r_capture <= reg_data;
          r_state   <= c_SEND;
        end
        c_SEND: begin
          if (!tx_busy) begin
            r_tx_data  <= w_send_byte;
            r_tx_start <= 1'b1;
            r_state    <= c_ACK;
          end
        end
        c_DONE: begin
          r_dump_done <= 1'b1;
          r_dump_busy <= 1'b0;
          r_reg_index <= 5'd0;
          r_state     <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign reg_index = r_reg_index;
  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign dump_busy = r_dump_busy;
  assign dump_done = r_dump_done;

endmodule
`default_nettype wire

// File: tb/tb_register_dump_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_register_dump_sequencer: randomized bench with a UART/register-file      |
// | model and a byte-level frame reference. Rev 1.0                             |
// +-----------------------------------------------------------------------------+
module tb_register_dump_sequencer;

  localparam int N     = 32;
  localparam int FRAME = 1 + 4 * N;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dump_start = 1'b0;
  logic [31:0] reg_data = 32'd0;
  logic [4:0]  reg_index;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        dump_busy;
  logic        dump_done;

  logic [31:0] regs [N];
  logic [31:0] snap [N];
  logic [7:0]  tx_q [$];
  int          busy_len = 10;
  int          busy_cnt = 0;
  logic        hold_busy = 1'b0;
  int          done_cnt = 0;
  int          proto_err = 0;
  int          base = 0;
  int          done_base = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  register_dump_sequencer #(.NUM_REGS(N), .HEADER_BYTE(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .dump_start (dump_start),
    .reg_data   (reg_data),
    .reg_index  (reg_index),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  always #5 clock = ~clock;

  // UART and register-file model, updated on the falling edge.
  always @(negedge clock) begin
    if (tx_start) begin
      if (tx_busy) proto_err++;
      tx_q.push_back(tx_data);
    end
    if (dump_done) done_cnt++;
    if (hold_busy) begin
      tx_busy = 1'b1;
    end else begin
      if (tx_start) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end
    reg_data = regs[reg_index];
  end

  function automatic logic [7:0] exp_byte(int j);
    logic [31:0] w;
    if (j == 0) return 8'hA5;
    w = snap[(j - 1) / 4];
    return w[8 * (3 - ((j - 1) % 4)) +: 8];
  endfunction

  task automatic randomize_regs();
    for (int i = 0; i < N; i++) regs[i] = $urandom;
  endtask

  task automatic take_snap();
    for (int i = 0; i < N; i++) snap[i] = regs[i];
  endtask

  task automatic start_dump();
    @(negedge clock); #1;
    base      = tx_q.size();
    done_base = done_cnt;
    dump_start = 1'b1;
    @(negedge clock); #1;
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit spam, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock); #1;
      if (done_cnt != done_base) begin
        dump_start = 1'b0;
        timed_out  = 1'b0;
        break;
      end
      if (spam) dump_start = ($urandom_range(0, 3) == 0);
    end
    dump_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({reg_index, tx_data, tx_start, dump_busy, dump_done} !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got idx=%0d data=%h start=%b busy=%b done=%b, want all 0",
               reg_index, tx_data, tx_start, dump_busy, dump_done);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic();
    bit to;
    for (int i = 0; i < N; i++) regs[i] = 32'd0;
    regs[1] = 32'h0000_000A;
    regs[3] = 32'h0000_000F;
    take_snap();
    busy_len = 10;
    start_dump();
    wait_done(6000, 1'b0, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL basic_timeout: dump_done not seen within budget"); end
    n_cmp++;
    if (tx_q.size() - base != FRAME) begin
      n_bad++; $display("FAIL basic_len: got %0d bytes, want %0d", tx_q.size() - base, FRAME);
    end
    for (int j = 0; j < FRAME && base + j < tx_q.size(); j++) begin
      n_cmp++;
      if (tx_q[base + j] !== exp_byte(j)) begin
        n_bad++; $display("FAIL basic_byte[%0d]: got %h, want %h", j, tx_q[base + j], exp_byte(j));
      end
    end
    repeat (4) @(negedge clock);
    n_cmp++;
    if (done_cnt - done_base != 1 || dump_busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: got %0d pulses busy=%b, want 1 pulse busy=0",
                        done_cnt - done_base, dump_busy);
    end
  endtask

  task automatic test_offsets();
    bit to;
    randomize_regs();
    regs[5]  = 32'hFFFF_FFFB;
    regs[15] = 32'h0000_2B67;
    take_snap();
    busy_len = $urandom_range(1, 12);
    start_dump();
    wait_done(6000, 1'b0, to);
    n_cmp++;
    if (to || tx_q.size() - base != FRAME) begin
      n_bad++; $display("FAIL offsets_len: got %0d bytes timeout=%b, want %0d", tx_q.size() - base, to, FRAME);
    end else begin
      n_cmp++;
      if ({tx_q[base+21], tx_q[base+22], tx_q[base+23], tx_q[base+24]} !== 32'hFFFF_FFFB) begin
        n_bad++; $display("FAIL offsets_reg5: got %h%h%h%h, want FFFFFFFB",
                          tx_q[base+21], tx_q[base+22], tx_q[base+23], tx_q[base+24]);
      end
      n_cmp++;
      if ({tx_q[base+61], tx_q[base+62], tx_q[base+63], tx_q[base+64]} !== 32'h0000_2B67) begin
        n_bad++; $display("FAIL offsets_reg15: got %h%h%h%h, want 00002B67",
                          tx_q[base+61], tx_q[base+62], tx_q[base+63], tx_q[base+64]);
      end
      for (int j = 0; j < FRAME; j++) begin
        n_cmp++;
        if (tx_q[base + j] !== exp_byte(j)) begin
          n_bad++; $display("FAIL offsets_byte[%0d]: got %h, want %h", j, tx_q[base + j], exp_byte(j));
        end
      end
    end
  endtask

  task automatic test_hold_busy();
    bit to;
    logic [7:0] t0;
    randomize_regs();
    take_snap();
    busy_len = 1;
    hold_busy = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    t0 = tx_data;
    start_dump();
    repeat (200) @(negedge clock);
    #1;
    n_cmp++;
    if (tx_q.size() - base != 0 || tx_data !== t0) begin
      n_bad++; $display("FAIL hold_busy: got %0d starts data=%h, want 0 starts data=%h",
                        tx_q.size() - base, tx_data, t0);
    end
    n_cmp++;
    if (dump_busy !== 1'b1) begin
      n_bad++; $display("FAIL hold_dump_busy: got %b, want 1", dump_busy);
    end
    hold_busy = 1'b0;
    wait_done(6000, 1'b0, to);
    n_cmp++;
    if (to || tx_q.size() - base != FRAME) begin
      n_bad++; $display("FAIL hold_len: got %0d bytes timeout=%b, want %0d", tx_q.size() - base, to, FRAME);
    end else begin
      for (int j = 0; j < FRAME; j++) begin
        n_cmp++;
        if (tx_q[base + j] !== exp_byte(j)) begin
          n_bad++; $display("FAIL hold_byte[%0d]: got %h, want %h", j, tx_q[base + j], exp_byte(j));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int f = 0; f < 2; f++) begin
      randomize_regs();
      take_snap();
      busy_len = $urandom_range(1, 6);
      start_dump();
      wait_done(6000, f == 0, to);
      repeat (5) @(negedge clock);
      #1;
      n_cmp++;
      if (to || tx_q.size() - base != FRAME || done_cnt - done_base != 1 || dump_busy !== 1'b0) begin
        n_bad++; $display("FAIL b2b_frame%0d: got %0d bytes %0d dones busy=%b, want %0d bytes 1 done busy=0",
                          f, tx_q.size() - base, done_cnt - done_base, dump_busy, FRAME);
      end else begin
        for (int j = 0; j < FRAME; j++) begin
          n_cmp++;
          if (tx_q[base + j] !== exp_byte(j)) begin
            n_bad++; $display("FAIL b2b%0d_byte[%0d]: got %h, want %h", f, j, tx_q[base + j], exp_byte(j));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int dc, qs;
    randomize_regs();
    take_snap();
    busy_len = $urandom_range(1, 8);
    start_dump();
    to = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock); #1;
      if (tx_q.size() - base >= 50) begin to = 1'b0; break; end
    end
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL rstmid_reach50: got %0d bytes, want 50", tx_q.size() - base); end
    dc = done_cnt;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({reg_index, tx_data, tx_start, dump_busy, dump_done} !== 16'd0) begin
      n_bad++; $display("FAIL rstmid_outputs: got idx=%0d data=%h start=%b busy=%b done=%b, want all 0",
                        reg_index, tx_data, tx_start, dump_busy, dump_done);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    qs = tx_q.size();
    repeat (20) @(negedge clock);
    #1;
    n_cmp++;
    if (done_cnt != dc || tx_q.size() != qs) begin
      n_bad++; $display("FAIL rstmid_quiet: got %0d dones %0d starts, want 0 and 0", done_cnt - dc, tx_q.size() - qs);
    end
    start_dump();
    n_cmp++;
    if (dump_busy !== 1'b1 || reg_index !== 5'd0) begin
      n_bad++; $display("FAIL rstmid_restart: got busy=%b idx=%0d, want busy=1 idx=0", dump_busy, reg_index);
    end
    wait_done(6000, 1'b0, to);
    n_cmp++;
    if (to || tx_q.size() - base != FRAME) begin
      n_bad++; $display("FAIL rstmid_len: got %0d bytes timeout=%b, want %0d", tx_q.size() - base, to, FRAME);
    end else begin
      for (int j = 0; j < FRAME; j++) begin
        n_cmp++;
        if (tx_q[base + j] !== exp_byte(j)) begin
          n_bad++; $display("FAIL rstmid_byte[%0d]: got %h, want %h", j, tx_q[base + j], exp_byte(j));
        end
      end
    end
  endtask

  task automatic test_snapshot();
    bit to;
    int k;
    randomize_regs();
    take_snap();
    k = $urandom_range(0, N - 1);
    busy_len = $urandom_range(2, 8);
    start_dump();
    to = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock); #1;
      if (tx_q.size() - base >= 1 + 4 * k + 2) begin to = 1'b0; break; end
    end
    regs[k] = ~regs[k];
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL snap_reach: got %0d bytes, want %0d", tx_q.size() - base, 1 + 4 * k + 2); end
    wait_done(6000, 1'b0, to);
    n_cmp++;
    if (to || tx_q.size() - base != FRAME) begin
      n_bad++; $display("FAIL snap_len: got %0d bytes timeout=%b, want %0d", tx_q.size() - base, to, FRAME);
    end else begin
      for (int j = 0; j < FRAME; j++) begin
        n_cmp++;
        if (tx_q[base + j] !== exp_byte(j)) begin
          n_bad++; $display("FAIL snap_byte[%0d] (reg %0d changed): got %h, want %h",
                            j, k, tx_q[base + j], exp_byte(j));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = 32'd0;
    test_reset();
    test_basic();
    test_offsets();
    test_hold_busy();
    test_back_to_back();
    test_reset_mid();
    test_snapshot();
    n_cmp++;
    if (proto_err != 0) begin
      n_bad++; $display("FAIL tx_start_while_busy: got %0d occurrences, want 0", proto_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_dump_sequencer.md
Name: register_dump_sequencer

Overview:
Downstream debug consumer of the register file's per-register debug outputs. On a dump request it walks register indices 0..NUM_REGS-1 and captures each 32-bit value. It streams a header byte followed by every register, MSB byte first, to the byte-wide UART transmitter over a start/busy handshake. Sits between the ID-stage register file debug outputs (via an external index mux) and the UART TX.

Parameters:
NUM_REGS, 32, number of registers dumped, indices 0..NUM_REGS-1 (max 32)
HEADER_BYTE, 8'hA5, frame-start byte sent before register data

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
dump_start  input  1  request a dump; sampled only in IDLE
reg_data  input  32  value of register selected by reg_index, valid one cycle after reg_index changes
reg_index  output  5  register select driven to external mux
tx_busy  input  1  UART transmitter busy; goes high the cycle after tx_start, stays high until byte shifted out
tx_data  output  8  byte to transmit, stable from tx_start until tx_busy falls
tx_start  output  1  one-cycle pulse launching tx_data
dump_busy  output  1  high from the cycle after dump_start is accepted until return to IDLE
dump_done  output  1  one-cycle pulse after last byte of frame completes

Behaviour:
- Reset (async, any state): state=IDLE, reg_index=0, tx_data=0, tx_start=0, dump_busy=0, dump_done=0, byte counter=0, capture register=0.
- States: IDLE, HEADER, SETTLE, LOAD, SEND, ACK, WAIT, DONE.
- IDLE: dump_start=1 -> HEADER; reg_index<=0, dump_busy<=1. dump_start=0 -> stay.
- HEADER: if tx_busy=0, tx_data<=HEADER_BYTE, tx_start<=1 (one cycle) -> ACK with header flag set; else hold.
- ACK: one cycle only; tx_start<=0 -> WAIT. (Absorbs tx_busy rise latency.)
- WAIT: stay while tx_busy=1. On tx_busy=0:
  - header flag set -> clear flag -> SETTLE.
  - byte counter <3 -> counter+1 -> SEND.
  - byte counter =3 and reg_index=NUM_REGS-1 -> DONE.
  - byte counter =3 otherwise -> reg_index+1, counter<=0 -> SETTLE.
- SETTLE: one-cycle wait for reg_data to reflect new reg_index -> LOAD.
- LOAD: capture<=reg_data -> SEND.
- SEND: tx_busy=0 -> tx_data<=capture[31-8*counter -: 8], tx_start<=1 -> ACK; else hold.
- DONE: dump_done<=1 for one cycle, dump_busy<=0, reg_index<=0 -> IDLE.
- Frame length: 1 + 4*NUM_REGS bytes (129 at default). Byte order: header, then per register bytes [31:24],[23:16],[15:8],[7:0].
- reg_data is captured once per register; changes during its 4 bytes are ignored (snapshot per register, not per frame).
- dump_start while dump_busy=1: ignored, no queuing. dump_start in the same cycle as DONE: ignored; a new dump needs dump_start in IDLE.
- reg_index holds its value across all 4 bytes of a register; it never exceeds NUM_REGS-1 and does not wrap mid-frame.
- tx_start is never asserted while tx_busy=1; never two tx_start pulses without an intervening WAIT exit.
- Reset mid-frame: aborts immediately, outputs return to reset values; no dump_done. A byte already in the UART completes there, outside this block's control.
- Minimum cycles per byte with an ideal TX (busy for 1 cycle): SEND->ACK->WAIT->next.

Test Plan:
- Reset then dump_start pulse; reg_data=32'h0000_000A for index 1, 32'h0000_000F for index 3, others 0; TX model busy 10 cycles -> 129 tx_start pulses. Bytes: A5, 00 00 00 00, 00 00 00 0A, 00 00 00 00, 00 00 00 0F, ... Then a single dump_done and dump_busy=0.
- reg_data=32'hFFFF_FFFB at index 5 and 32'h0000_2B67 at index 15 -> bytes FF FF FF FB and 00 00 2B 67 appear at frame offsets 21-24 and 61-64.
- Hold tx_busy=1 for 200 cycles before the header -> tx_start stays 0 and tx_data is unchanged until tx_busy falls, then one header pulse.
- Assert dump_start repeatedly mid-frame -> frame length still 129 and exactly one dump_done. dump_start after dump_done -> a second full frame.
- Assert reset after 50 bytes -> all outputs are 0 in the same cycle, no dump_done. A fresh dump_start restarts with the A5 header and reg_index=0.
- Change reg_data between bytes 2 and 3 of a register -> all 4 bytes reflect the value captured in LOAD.
